// File: rtl/alien_formation_motion_pkg.sv
// Shared types and default screen geometry for the alien formation motion engine.
package galaxian_pkg;

  typedef enum logic [1:0] {
    MODE_EASY   = 2'b00,
    MODE_HARD   = 2'b01,
    MODE_HOLD_A = 2'b10,
    MODE_HOLD_B = 2'b11
  } alien_mode_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_LAUNCH,
    D_DIVE
  } dive_state_t;

  localparam int DEF_NUM_ALIENS    = 10;
  localparam int DEF_FORM_X0       = 160;
  localparam int DEF_FORM_Y0       = 64;
  localparam int DEF_FORM_W        = 320;
  localparam int DEF_ALIEN_PITCH   = 32;
  localparam int DEF_X_LEFT_LIMIT  = 16;
  localparam int DEF_X_RIGHT_LIMIT = 624;
  localparam int DEF_EASY_STEP     = 1;
  localparam int DEF_HARD_STEP     = 2;
  localparam int DEF_DROP_STEP     = 8;
  localparam int DEF_Y_MAX         = 400;
  localparam int DEF_DIVE_PERIOD   = 120;
  localparam int DEF_DIVE_SPEED    = 4;
  localparam int DEF_DIVE_Y_END    = 440;

endpackage

// File: rtl/alien_formation_motion_if.sv
// Mode/alive/player inputs and formation/diver outputs of the motion engine.
interface alien_formation_motion_if #(
  parameter int NUM_ALIENS = 10
);
  logic [1:0]            alien_control;
  logic [NUM_ALIENS-1:0] alive_mask;
  logic [9:0]            player_x;
  logic [9:0]            form_x;
  logic [9:0]            form_y;
  logic                  form_dir;
  logic                  reached_bottom;
  logic                  dive_active;
  logic [3:0]            dive_idx;
  logic [9:0]            dive_x;
  logic [9:0]            dive_y;

  modport master (
    output alien_control, alive_mask, player_x,
    input  form_x, form_y, form_dir, reached_bottom,
    input  dive_active, dive_idx, dive_x, dive_y
  );

  modport slave (
    input  alien_control, alive_mask, player_x,
    output form_x, form_y, form_dir, reached_bottom,
    output dive_active, dive_idx, dive_x, dive_y
  );
endinterface

// File: rtl/alien_formation_motion_dive_selector.sv
// Round-robin pick of the next diver: lowest alive slot at or above rr_ptr, else lowest alive slot.
module dive_selector #(
  parameter int NUM_ALIENS = 10
) (
  input  logic [NUM_ALIENS-1:0] alive_mask,
  input  logic [3:0]            rr_ptr,
  output logic [3:0]            sel,
  output logic                  any_alive
);

  logic [3:0] hi_idx;
  logic [3:0] lo_idx;
  logic       hi_found;
  logic       lo_found;

  // Scanning downward lets the last hit be the lowest index in each range.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
      if (alive_mask[i]) begin
        lo_idx   = 4'(i);
        lo_found = 1'b1;
        if (i >= int'(rr_ptr)) begin
          hi_idx   = 4'(i);
          hi_found = 1'b1;
        end
      end
    end
    any_alive = lo_found;
    sel       = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/alien_formation_motion.sv
// Per-frame formation sweep with edge drops, plus a single round-robin diver in HARD mode.
module alien_formation_motion
  import galaxian_pkg::*;
#(
  parameter int NUM_ALIENS    = DEF_NUM_ALIENS,
  parameter int FORM_X0       = DEF_FORM_X0,
  parameter int FORM_Y0       = DEF_FORM_Y0,
  parameter int FORM_W        = DEF_FORM_W,
  parameter int ALIEN_PITCH   = DEF_ALIEN_PITCH,
  parameter int X_LEFT_LIMIT  = DEF_X_LEFT_LIMIT,
  parameter int X_RIGHT_LIMIT = DEF_X_RIGHT_LIMIT,
  parameter int EASY_STEP     = DEF_EASY_STEP,
  parameter int HARD_STEP     = DEF_HARD_STEP,
  parameter int DROP_STEP     = DEF_DROP_STEP,
  parameter int Y_MAX         = DEF_Y_MAX,
  parameter int DIVE_PERIOD   = DEF_DIVE_PERIOD,
  parameter int DIVE_SPEED    = DEF_DIVE_SPEED,
  parameter int DIVE_Y_END    = DEF_DIVE_Y_END
) (
  input logic                    Clk,
  input logic                    Reset,
  alien_formation_motion_if.slave bus
);

  localparam int TW = $clog2(DIVE_PERIOD);

  alien_mode_t mode;
  logic [10:0] step;

  logic [9:0]  form_x, form_x_n;
  logic [9:0]  form_y, form_y_n;
  logic        form_dir, form_dir_n;
  logic        reached_bottom, reached_bottom_n;
  logic [9:0]  drop_y;

  dive_state_t state, state_n;
  logic [TW-1:0] dive_timer, dive_timer_n;
  logic [3:0]  rr_ptr, rr_ptr_n;
  logic [3:0]  dive_idx, dive_idx_n;
  logic [9:0]  dive_x, dive_x_n;
  logic [9:0]  dive_y, dive_y_n;
  logic        dive_active, dive_active_n;
  logic [3:0]  sel;
  logic        any_alive;

  assign mode = alien_mode_t'(bus.alien_control);
  assign step = (mode == MODE_HARD) ? 11'(HARD_STEP) : 11'(EASY_STEP);

  dive_selector #(.NUM_ALIENS(NUM_ALIENS)) u_sel (
    .alive_mask (bus.alive_mask),
    .rr_ptr     (rr_ptr),
    .sel        (sel),
    .any_alive  (any_alive)
  );

  // Sweep: edge tests use 11-bit sums so the right-edge compare cannot wrap.
  always_comb begin
    form_x_n         = form_x;
    form_y_n         = form_y;
    form_dir_n       = form_dir;
    reached_bottom_n = reached_bottom;
    drop_y = (form_y >= 10'(Y_MAX - DROP_STEP)) ? 10'(Y_MAX) : form_y + 10'(DROP_STEP);
    if (mode == MODE_EASY || mode == MODE_HARD) begin
      if (!form_dir) begin
        if ({1'b0, form_x} + 11'(FORM_W) + step > 11'(X_RIGHT_LIMIT)) begin
          form_x_n   = 10'(X_RIGHT_LIMIT - FORM_W);
          form_dir_n = 1'b1;
          form_y_n   = drop_y;
        end else begin
          form_x_n = 10'({1'b0, form_x} + step);
        end
      end else begin
        if ({1'b0, form_x} < 11'(X_LEFT_LIMIT) + step) begin
          form_x_n   = 10'(X_LEFT_LIMIT);
          form_dir_n = 1'b0;
          form_y_n   = drop_y;
        end else begin
          form_x_n = 10'({1'b0, form_x} - step);
        end
      end
    end
    if (form_y_n == 10'(Y_MAX)) reached_bottom_n = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= D_IDLE;
    else       state <= state_n;
  end

  // Dive FSM: the launch latches the live selector result and formation origin.
  always_comb begin
    state_n       = state;
    dive_timer_n  = dive_timer;
    rr_ptr_n      = rr_ptr;
    dive_idx_n    = dive_idx;
    dive_x_n      = dive_x;
    dive_y_n      = dive_y;
    dive_active_n = dive_active;
    case (state)
      D_IDLE: begin
        if (mode == MODE_HARD) begin
          if (dive_timer == TW'(DIVE_PERIOD - 1)) begin
            dive_timer_n = '0;
            if (any_alive) state_n = D_LAUNCH;
          end else begin
            dive_timer_n = dive_timer + 1'b1;
          end
        end
      end
      D_LAUNCH: begin
        dive_idx_n    = sel;
        rr_ptr_n      = (int'(sel) == NUM_ALIENS - 1) ? 4'd0 : sel + 4'd1;
        dive_x_n      = 10'({1'b0, form_x} + 11'(int'(sel) * ALIEN_PITCH));
        dive_y_n      = form_y;
        dive_active_n = 1'b1;
        state_n       = D_DIVE;
      end
      D_DIVE: begin
        dive_y_n = dive_y + 10'(DIVE_SPEED);
        if (dive_x < bus.player_x)      dive_x_n = dive_x + 10'd1;
        else if (dive_x > bus.player_x) dive_x_n = dive_x - 10'd1;
        if (!bus.alive_mask[dive_idx] ||
            ({1'b0, dive_y} + 11'(DIVE_SPEED) >= 11'(DIVE_Y_END))) begin
          dive_active_n = 1'b0;
          state_n       = D_IDLE;
        end
      end
      default: state_n = D_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      form_x         <= 10'(FORM_X0);
      form_y         <= 10'(FORM_Y0);
      form_dir       <= 1'b0;
      reached_bottom <= 1'b0;
      dive_timer     <= '0;
      rr_ptr         <= '0;
      dive_idx       <= '0;
      dive_x         <= '0;
      dive_y         <= '0;
      dive_active    <= 1'b0;
    end else begin
      form_x         <= form_x_n;
      form_y         <= form_y_n;
      form_dir       <= form_dir_n;
      reached_bottom <= reached_bottom_n;
      dive_timer     <= dive_timer_n;
      rr_ptr         <= rr_ptr_n;
      dive_idx       <= dive_idx_n;
      dive_x         <= dive_x_n;
      dive_y         <= dive_y_n;
      dive_active    <= dive_active_n;
    end
  end

  assign bus.form_x         = form_x;
  assign bus.form_y         = form_y;
  assign bus.form_dir       = form_dir;
  assign bus.reached_bottom = reached_bottom;
  assign bus.dive_active    = dive_active;
  assign bus.dive_idx       = dive_idx;
  assign bus.dive_x         = dive_x;
  assign bus.dive_y         = dive_y;

endmodule

// File: tb/tb_alien_formation_motion.sv
// Directed frame-by-frame bench for the alien formation motion engine.
module tb_alien_formation_motion;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  alien_formation_motion_if #(.NUM_ALIENS(10)) bus ();

  alien_formation_motion dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One frame: inputs change and outputs are sampled 1 time unit after the edge.
  task automatic frame();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_active(input logic level, input int limit, output int n);
    n = 0;
    while (bus.dive_active !== level && n < limit) begin
      frame();
      n++;
    end
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_form_x"}, 32'(bus.form_x), 160);
    check({p, "_form_y"}, 32'(bus.form_y), 64);
    check({p, "_form_dir"}, 32'(bus.form_dir), 0);
    check({p, "_reached_bottom"}, 32'(bus.reached_bottom), 0);
    check({p, "_dive_active"}, 32'(bus.dive_active), 0);
    check({p, "_dive_idx"}, 32'(bus.dive_idx), 0);
    check({p, "_dive_x"}, 32'(bus.dive_x), 0);
    check({p, "_dive_y"}, 32'(bus.dive_y), 0);
  endtask

  initial begin
    int n;
    int bad;
    int toggles;
    logic prev_dir;
    logic [9:0] sx, sy, sdx, sdy;
    logic sd;

    bus.alien_control = 2'b00;
    bus.alive_mask    = 10'b0000001100;
    bus.player_x      = 10'd500;
    Reset = 1'b1;
    frame();
    frame();
    Reset = 1'b0;
    check_reset_state("reset");

    // EASY sweep to the right edge and back
    frame();
    check("easy_f1_x", 32'(bus.form_x), 161);
    check("easy_f1_y", 32'(bus.form_y), 64);
    check("easy_f1_dir", 32'(bus.form_dir), 0);
    repeat (143) frame();
    check("easy_f144_x", 32'(bus.form_x), 304);
    frame();
    check("easy_f145_x", 32'(bus.form_x), 304);
    check("easy_f145_dir", 32'(bus.form_dir), 1);
    check("easy_f145_y", 32'(bus.form_y), 72);
    frame();
    check("easy_f146_x", 32'(bus.form_x), 303);
    check("easy_timer_idle", 32'(bus.dive_active), 0);

    // HARD: first launch 121 frames after entering the mode
    bus.alien_control = 2'b01;
    repeat (120) frame();
    check("hard_f120_x", 32'(bus.form_x), 63);
    check("hard_f120_active", 32'(bus.dive_active), 0);
    frame();
    check("launch1_active", 32'(bus.dive_active), 1);
    check("launch1_idx", 32'(bus.dive_idx), 2);
    check("launch1_x", 32'(bus.dive_x), 127);
    check("launch1_y", 32'(bus.dive_y), 72);
    frame();
    check("dive1_y", 32'(bus.dive_y), 76);
    check("dive1_x", 32'(bus.dive_x), 128);
    wait_active(1'b0, 200, n);
    check("dive1_end_frames", 32'(n), 91);
    check("dive1_end_y", 32'(bus.dive_y), 440);
    check("dive1_end_x", 32'(bus.dive_x), 219);

    // Second launch picks the next alive slot
    wait_active(1'b1, 300, n);
    check("launch2_frames", 32'(n), 121);
    check("launch2_idx", 32'(bus.dive_idx), 3);
    frame();
    bus.alive_mask = 10'b0000000100;
    frame();
    check("shot_active", 32'(bus.dive_active), 0);

    // Third launch wraps back to slot 2; timer restarted at the shot
    wait_active(1'b1, 300, n);
    check("launch3_frames", 32'(n), 121);
    check("launch3_idx", 32'(bus.dive_idx), 2);

    // HOLD freezes the sweep while the diver continues
    sx = bus.form_x; sy = bus.form_y; sd = bus.form_dir;
    sdx = bus.dive_x; sdy = bus.dive_y;
    bus.alien_control = 2'b10;
    bus.player_x = 10'd0;
    repeat (50) frame();
    check("hold_x", 32'(bus.form_x), 32'(sx));
    check("hold_y", 32'(bus.form_y), 32'(sy));
    check("hold_dir", 32'(bus.form_dir), 32'(sd));
    check("hold_dive_active", 32'(bus.dive_active), 1);
    check("hold_dive_dy", 32'(bus.dive_y - sdy), 200);
    check("hold_dive_dx", 32'(sdx - bus.dive_x), 50);
    wait_active(1'b0, 200, n);
    check("hold_dive_done", 32'(bus.dive_active), 0);
    check("hold_dive_end_y", 32'(bus.dive_y), 440);

    // Timer holds across HOLD: 60 HARD + 50 HOLD + 61 HARD frames to launch
    bus.alien_control = 2'b01;
    bus.player_x = 10'd500;
    repeat (60) frame();
    bus.alien_control = 2'b11;
    repeat (50) frame();
    check("hold_no_launch", 32'(bus.dive_active), 0);
    bus.alien_control = 2'b01;
    wait_active(1'b1, 200, n);
    check("held_timer_frames", 32'(n), 61);
    check("launch4_idx", 32'(bus.dive_idx), 2);
    bus.alive_mask = 10'b0;
    frame();
    check("all_dead_active", 32'(bus.dive_active), 0);

    // Drive the formation to the bottom and through further bounces
    n = 0;
    while (bus.form_y != 10'd400 && n < 20000) begin
      frame();
      n++;
    end
    check("bottom_y", 32'(bus.form_y), 400);
    check("bottom_flag", 32'(bus.reached_bottom), 1);
    bad = 0;
    toggles = 0;
    prev_dir = bus.form_dir;
    for (int i = 0; i < 300; i++) begin
      frame();
      if (bus.form_y != 10'd400 || bus.reached_bottom != 1'b1) bad++;
      if (bus.form_dir != prev_dir) toggles++;
      prev_dir = bus.form_dir;
    end
    check("bottom_stays", 32'(bad), 0);
    check("bottom_bounces", 32'(toggles >= 2), 1);
    check("no_dive_when_dead", 32'(bus.dive_active), 0);

    // Reset mid-dive restores everything
    bus.alive_mask = 10'b0000000100;
    wait_active(1'b1, 300, n);
    check("final_launch", 32'(bus.dive_active), 1);
    Reset = 1'b1;
    frame();
    check_reset_state("midreset");
    Reset = 1'b0;
    bus.alien_control = 2'b00;
    frame();
    check("post_reset_x", 32'(bus.form_x), 161);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
